reg_file_sb: RTL and testbench

Parametrised successor to the 8×8 CPU register file. It provides two asynchronous read ports and one synchronous ALU write port. It adds a single-entry load scoreboard: a data-memory load reserves its destination register, and the returned data is written when memory completes. Read ports forward the returning load data and raise STALL on read-after-load hazards. The block sits between the decode/ALU datapath and the data-memory/cache interface.

---
 rtl/reg_file_sb.sv | 135 +++++++++++++
 tb/tb_reg_file_sb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one ALU write port and a
// single-entry load scoreboard that forwards returning load data and flags hazards.
module reg_file_sb #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned ZERO_REG   = 0
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [DATA_WIDTH-1:0] IN,
   input  logic [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                  WRITE,
   input  logic                  BUSYWAIT,
   input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
   input  logic                  RD1_EN,
   input  logic                  RD2_EN,
   input  logic                  LOAD_ISSUE,
   input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
   input  logic                  LOAD_DONE,
   input  logic [DATA_WIDTH-1:0] LOAD_DATA,
   output logic [DATA_WIDTH-1:0] OUT1,
   output logic [DATA_WIDTH-1:0] OUT2,
   output logic                  STALL,
   output logic                  PENDING,
   output logic                  WAW_ERR,
   output logic                  ISSUE_ERR
);

   localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
   localparam bit          ZERO_EN = (ZERO_REG != 0);

   typedef enum logic {S_IDLE, S_PEND} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  waw_err_q, waw_err_d;
   logic                  issue_err_q, issue_err_d;
   logic                  load_we;
   logic                  alu_we;
   logic                  alu_req;
   logic                  issue_zero;
   logic                  fwd;
   logic                  zero1, zero2;

   assign alu_req    = WRITE & ~BUSYWAIT;
   assign issue_zero = ZERO_EN && (LOAD_ADDR == '0);

   // Scoreboard FSM plus ALU write arbitration against the reserved register
   always_comb begin
      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      load_we     = 1'b0;
      issue_err_d = 1'b0;
      waw_err_d   = 1'b0;
      alu_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (LOAD_ISSUE) begin
               if (issue_zero) begin
                  issue_err_d = 1'b1;
               end else begin
                  state_d     = S_PEND;
                  pend_addr_d = LOAD_ADDR;
               end
            end
         end
         S_PEND: begin
            if (LOAD_DONE) begin
               load_we = 1'b1;
               state_d = S_IDLE;
               if (LOAD_ISSUE) begin
                  if (issue_zero) begin
                     issue_err_d = 1'b1;
                  end else begin
                     state_d     = S_PEND;
                     pend_addr_d = LOAD_ADDR;
                  end
               end
            end else if (LOAD_ISSUE) begin
               issue_err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (alu_req) begin
         if (state_q == S_PEND && INADDRESS == pend_addr_q) begin
            waw_err_d = 1'b1;
         end else if (!(ZERO_EN && INADDRESS == '0)) begin
            alu_we = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         pend_addr_q <= '0;
         waw_err_q   <= 1'b0;
         issue_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         waw_err_q   <= waw_err_d;
         issue_err_q <= issue_err_d;
      end
   end

   // Load write is applied last; the two writes never target the same register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
      end else begin
         if (alu_we)  regs[INADDRESS]   <= IN;
         if (load_we) regs[pend_addr_q] <= LOAD_DATA;
      end
   end

   assign fwd   = (state_q == S_PEND) && LOAD_DONE;
   assign zero1 = ZERO_EN && (OUT1ADDRESS == '0);
   assign zero2 = ZERO_EN && (OUT2ADDRESS == '0);

   assign OUT1 = zero1 ? '0 : (fwd && OUT1ADDRESS == pend_addr_q) ? LOAD_DATA : regs[OUT1ADDRESS];
   assign OUT2 = zero2 ? '0 : (fwd && OUT2ADDRESS == pend_addr_q) ? LOAD_DATA : regs[OUT2ADDRESS];

   assign STALL = (state_q == S_PEND) && !LOAD_DONE &&
                  ((RD1_EN && !zero1 && OUT1ADDRESS == pend_addr_q) ||
                   (RD2_EN && !zero2 && OUT2ADDRESS == pend_addr_q));

   assign PENDING   = (state_q == S_PEND);
   assign WAW_ERR   = waw_err_q;
   assign ISSUE_ERR = issue_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (8x8 plain, 16x16 with zero register)
// driven by directed and random stimulus against a behavioural model.
module tb_reg_file_sb;

   logic clk;
   logic rst_n;

   // per-instance inputs, index 0 = 8-bit/3-bit, index 1 = 16-bit/4-bit zero-reg
   logic [15:0] din  [2];
   logic [3:0]  waddr[2];
   logic        wr   [2];
   logic        bw   [2];
   logic [3:0]  ra1  [2];
   logic [3:0]  ra2  [2];
   logic        re1  [2];
   logic        re2  [2];
   logic        li   [2];
   logic [3:0]  ladr [2];
   logic        ld   [2];
   logic [15:0] ldat [2];

   logic [7:0]  o1a, o2a;
   logic [15:0] o1b, o2b;
   logic        stall_a, pend_a, waw_a, ierr_a;
   logic        stall_b, pend_b, waw_b, ierr_b;

   // reference model state
   logic [15:0] mem    [2][16];
   bit          pend_m [2];
   logic [3:0]  paddr_m[2];
   bit          waw_m  [2];
   bit          ierr_m [2];

   int n_checks = 0;
   int n_pass   = 0;

   reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0)) u_a (
      .CLK(clk), .RESET_N(rst_n),
      .IN(din[0][7:0]), .INADDRESS(waddr[0][2:0]), .WRITE(wr[0]), .BUSYWAIT(bw[0]),
      .OUT1ADDRESS(ra1[0][2:0]), .OUT2ADDRESS(ra2[0][2:0]), .RD1_EN(re1[0]), .RD2_EN(re2[0]),
      .LOAD_ISSUE(li[0]), .LOAD_ADDR(ladr[0][2:0]), .LOAD_DONE(ld[0]), .LOAD_DATA(ldat[0][7:0]),
      .OUT1(o1a), .OUT2(o2a), .STALL(stall_a), .PENDING(pend_a),
      .WAW_ERR(waw_a), .ISSUE_ERR(ierr_a)
   );

   reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1)) u_b (
      .CLK(clk), .RESET_N(rst_n),
      .IN(din[1]), .INADDRESS(waddr[1]), .WRITE(wr[1]), .BUSYWAIT(bw[1]),
      .OUT1ADDRESS(ra1[1]), .OUT2ADDRESS(ra2[1]), .RD1_EN(re1[1]), .RD2_EN(re2[1]),
      .LOAD_ISSUE(li[1]), .LOAD_ADDR(ladr[1]), .LOAD_DONE(ld[1]), .LOAD_DATA(ldat[1]),
      .OUT1(o1b), .OUT2(o2b), .STALL(stall_b), .PENDING(pend_b),
      .WAW_ERR(waw_b), .ISSUE_ERR(ierr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit is_zero(int k, logic [3:0] a);
      return (k == 1) && (a == 4'd0);
   endfunction

   function automatic logic [15:0] mread(int k, logic [3:0] a);
      if (is_zero(k, a)) return 16'h0;
      if (pend_m[k] && ld[k] && a == paddr_m[k]) return ldat[k];
      return mem[k][a];
   endfunction

   function automatic bit mstall(int k);
      return pend_m[k] && !ld[k] &&
             ((re1[k] && !is_zero(k, ra1[k]) && ra1[k] == paddr_m[k]) ||
              (re2[k] && !is_zero(k, ra2[k]) && ra2[k] == paddr_m[k]));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) mem[k][i] = 16'h0;
         pend_m[k] = 0; paddr_m[k] = 4'd0; waw_m[k] = 0; ierr_m[k] = 0;
      end
   endtask

   // one clock edge of the architectural rules
   task automatic model_step(int k);
      bit acc, lw;
      waw_m[k] = 0;
      ierr_m[k] = 0;
      lw = pend_m[k] && ld[k];
      if (wr[k] && !bw[k]) begin
         if (pend_m[k] && waddr[k] == paddr_m[k]) waw_m[k] = 1;
         else if (!is_zero(k, waddr[k])) mem[k][waddr[k]] = din[k];
      end
      if (lw) mem[k][paddr_m[k]] = ldat[k];
      acc = li[k] && !is_zero(k, ladr[k]) && (!pend_m[k] || ld[k]);
      if (li[k] && !acc) ierr_m[k] = 1;
      if (acc) begin
         pend_m[k]  = 1;
         paddr_m[k] = ladr[k];
      end else if (lw) begin
         pend_m[k] = 0;
      end
   endtask

   task automatic check_dut(int k);
      logic [15:0] g1, g2;
      logic gs, gp, gw, gi;
      if (k == 0) begin
         g1 = 16'(o1a); g2 = 16'(o2a); gs = stall_a; gp = pend_a; gw = waw_a; gi = ierr_a;
      end else begin
         g1 = o1b; g2 = o2b; gs = stall_b; gp = pend_b; gw = waw_b; gi = ierr_b;
      end
      check($sformatf("d%0d_out1", k), g1, mread(k, ra1[k]));
      check($sformatf("d%0d_out2", k), g2, mread(k, ra2[k]));
      check($sformatf("d%0d_stall", k), 16'(gs), 16'(mstall(k)));
      check($sformatf("d%0d_pending", k), 16'(gp), 16'(pend_m[k]));
      check($sformatf("d%0d_waw_err", k), 16'(gw), 16'(waw_m[k]));
      check($sformatf("d%0d_issue_err", k), 16'(gi), 16'(ierr_m[k]));
   endtask

   // entered just after a falling edge with inputs applied; leaves on the next falling edge
   task automatic cycle();
      #1;
      check_dut(0);
      check_dut(1);
      @(posedge clk);
      if (!rst_n) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         din[k] = '0; waddr[k] = '0; wr[k] = 0; bw[k] = 0;
         ra1[k] = '0; ra2[k] = '0; re1[k] = 0; re2[k] = 0;
         li[k] = 0; ladr[k] = '0; ld[k] = 0; ldat[k] = '0;
      end
   endtask

   task automatic randomize_inputs();
      for (int k = 0; k < 2; k++) begin
         logic [15:0] dm;
         logic [3:0]  am;
         dm = (k == 0) ? 16'h00FF : 16'hFFFF;
         am = (k == 0) ? 4'h7 : 4'hF;
         din[k]   = 16'($urandom) & dm;
         waddr[k] = 4'($urandom) & am;
         wr[k]    = ($urandom_range(0, 1) == 1);
         bw[k]    = ($urandom_range(0, 3) == 0);
         ra1[k]   = 4'($urandom) & am;
         ra2[k]   = 4'($urandom) & am;
         re1[k]   = ($urandom_range(0, 3) != 0);
         re2[k]   = ($urandom_range(0, 3) != 0);
         li[k]    = ($urandom_range(0, 3) == 0);
         ladr[k]  = 4'($urandom) & am;
         ld[k]    = ($urandom_range(0, 9) < 3);
         ldat[k]  = 16'($urandom) & dm;
      end
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // reset state, then basic writes
      cycle();
      wr[0] = 1; waddr[0] = 4'd3; din[0] = 16'h005A;
      cycle();
      waddr[0] = 4'd7; din[0] = 16'h00FF;
      cycle();
      clear_inputs();
      ra1[0] = 4'd3; ra2[0] = 4'd7;
      #1;
      check("basic_r3", 16'(o1a), 16'h005A);
      check("basic_r7", 16'(o2a), 16'h00FF);
      cycle();

      // asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out1", 16'(o1a), 16'h0);
      check("async_rst_out2", 16'(o2a), 16'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // load hazard and forwarding
      li[0] = 1; ladr[0] = 4'd2;
      cycle();
      li[0] = 0; re1[0] = 1; ra1[0] = 4'd2;
      for (int i = 0; i < 3; i++) begin
         #1 check("hazard_stall", 16'(stall_a), 16'h1);
         cycle();
      end
      ld[0] = 1; ldat[0] = 16'h003C;
      #1;
      check("fwd_stall", 16'(stall_a), 16'h0);
      check("fwd_out1", 16'(o1a), 16'h003C);
      cycle();
      ld[0] = 0;
      #1;
      check("load_pending", 16'(pend_a), 16'h0);
      check("load_r2", 16'(o1a), 16'h003C);
      cycle();

      // WAW drop and BUSYWAIT
      clear_inputs();
      li[0] = 1; ladr[0] = 4'd4;
      cycle();
      li[0] = 0; wr[0] = 1; waddr[0] = 4'd4; din[0] = 16'h0011;
      cycle();
      wr[0] = 0;
      #1 check("waw_pulse", 16'(waw_a), 16'h1);
      cycle();
      ld[0] = 1; ldat[0] = 16'h0044;
      cycle();
      clear_inputs();
      wr[0] = 1; waddr[0] = 4'd5; din[0] = 16'h0022; bw[0] = 1; ra2[0] = 4'd5;
      cycle();
      #1 check("busy_r5", 16'(o2a), 16'h0);
      bw[0] = 0;
      cycle();
      wr[0] = 0;
      #1 check("write_r5", 16'(o2a), 16'h0022);
      cycle();

      // simultaneous done / issue / ALU write
      clear_inputs();
      li[0] = 1; ladr[0] = 4'd1;
      cycle();
      li[0] = 0;
      ld[0] = 1; ldat[0] = 16'h0077; li[0] = 1; ladr[0] = 4'd6;
      wr[0] = 1; waddr[0] = 4'd0; din[0] = 16'h0009;
      cycle();
      clear_inputs();
      re1[0] = 1; ra1[0] = 4'd6; ra2[0] = 4'd1;
      #1;
      check("simul_stall", 16'(stall_a), 16'h1);
      check("simul_pending", 16'(pend_a), 16'h1);
      check("simul_r1", 16'(o2a), 16'h0077);
      ra2[0] = 4'd0;
      #1 check("simul_r0", 16'(o2a), 16'h0009);
      li[0] = 1; ladr[0] = 4'd3;
      cycle();
      li[0] = 0;
      #1 check("issue_err", 16'(ierr_a), 16'h1);
      ld[0] = 1; ldat[0] = 16'h00C3;
      cycle();
      clear_inputs();

      // zero register instance
      wr[1] = 1; waddr[1] = 4'd0; din[1] = 16'hBEEF;
      cycle();
      waddr[1] = 4'd15;
      cycle();
      wr[1] = 0; ra1[1] = 4'd0; ra2[1] = 4'd15;
      #1;
      check("zr_r0", o1b, 16'h0);
      check("zr_r15", o2b, 16'hBEEF);
      li[1] = 1; ladr[1] = 4'd0;
      cycle();
      li[1] = 0;
      #1;
      check("zr_issue_err", 16'(ierr_b), 16'h1);
      check("zr_pending", 16'(pend_b), 16'h0);
      cycle();

      // reset mid-load discards the reservation
      clear_inputs();
      li[0] = 1; ladr[0] = 4'd5;
      cycle();
      li[0] = 0;
      rst_n = 1'b0;
      model_reset();
      cycle();
      rst_n = 1'b1;
      ld[0] = 1; ldat[0] = 16'h00AA; ra1[0] = 4'd5;
      cycle();
      ld[0] = 0;
      #1;
      check("midrst_r5", 16'(o1a), 16'h0);
      check("midrst_pending", 16'(pend_a), 16'h0);
      cycle();

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         randomize_inputs();
         if ($urandom_range(0, 249) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         cycle();
      end
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
